// File: rtl/mbist_march_ctrl_if.sv
// ----------------------------------------------------------------------------
// mbist_march_ctrl_if
// Memory-side bus between the March C- BIST controller and a synchronous
// single-port memory.
//   mem_en     controller -> memory  memory enable
//   mem_we     controller -> memory  1 = write, 0 = read
//   mem_addr   controller -> memory  word address
//   mem_wdata  controller -> memory  write data
//   mem_rdata  memory -> controller  registered read data (1 cycle after read)
// Modports: master = BIST controller, slave = memory.
// ----------------------------------------------------------------------------
interface mbist_march_ctrl_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
);
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mbist_march_ctrl.sv
// ----------------------------------------------------------------------------
// mbist_march_ctrl
// Built-in self-test controller running March C- over words 0..MEM_SIZE-1 of
// a synchronous single-port memory. Reports pass/fail and streams every
// miscompare address to the repair logic.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             begin a test (accepted only in IDLE or DONE)
//   mem               memory bus (master side of mbist_march_ctrl_if)
//   bist_busy         high from start accept until DONE
//   bist_done         high in DONE until next start/reset
//   bist_pass         valid with bist_done, 1 = no miscompares
//   fail_valid        one-cycle pulse per miscompare
//   fail_addr         miscompare address, valid with fail_valid
//   fail_count        saturating miscompare count for this run
//   first_fail_addr   address of the first miscompare, 0 if none
// ----------------------------------------------------------------------------
module mbist_march_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_SIZE   = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    mbist_march_ctrl_if.master    mem,
    output logic                  bist_busy,
    output logic                  bist_done,
    output logic                  bist_pass,
    output logic                  fail_valid,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [CNT_WIDTH-1:0]  fail_count,
    output logic [ADDR_WIDTH-1:0] first_fail_addr
);

    typedef enum logic [3:0] {
        S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(MEM_SIZE - 1);

    // state_reg/addr_reg/phase_reg always describe the op currently on the bus.
    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic                  phase_reg, phase_next;
    logic                  run_end;

    logic                  mem_en_reg, mem_we_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [DATA_WIDTH-1:0] mem_wdata_reg;

    // Compare pipeline: a read seen on the bus is checked one edge later,
    // when the memory's registered data is available.
    logic                  chk_reg, chk_exp_reg;
    logic [ADDR_WIDTH-1:0] chk_addr_reg;
    logic                  drain_reg;
    logic                  miscompare;

    assign mem.mem_en    = mem_en_reg;
    assign mem.mem_we    = mem_we_reg;
    assign mem.mem_addr  = mem_addr_reg;
    assign mem.mem_wdata = mem_wdata_reg;

    function automatic logic elem_down(input state_t s);
        return (s == S_M3) || (s == S_M4);
    endfunction

    function automatic logic elem_pair(input state_t s);
        return (s == S_M1) || (s == S_M2) || (s == S_M3) || (s == S_M4);
    endfunction

    // Background written by the write op of an element (w1 in M1/M3).
    function automatic logic write_bit(input state_t s);
        return (s == S_M1) || (s == S_M3);
    endfunction

    // Background expected by the read op of an element (r1 in M2/M4).
    function automatic logic read_bit(input state_t s);
        return (s == S_M2) || (s == S_M4);
    endfunction

    // M0 is write-only; in paired elements phase 1 is the write.
    function automatic logic op_is_write(input state_t s, input logic ph);
        return (s == S_M0) || ph;
    endfunction

    // Position of the op following the one currently driven.
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        phase_next = 1'b0;
        run_end    = 1'b0;
        if (elem_pair(state_reg) && !phase_reg) begin
            phase_next = 1'b1;
        end else if (addr_reg != (elem_down(state_reg) ? '0 : ADDR_LAST)) begin
            addr_next = elem_down(state_reg) ? addr_reg - ADDR_WIDTH'(1)
                                             : addr_reg + ADDR_WIDTH'(1);
        end else begin
            // Address counter wraps only here, between elements.
            case (state_reg)
                S_M0:    begin state_next = S_M1; addr_next = '0;        end
                S_M1:    begin state_next = S_M2; addr_next = '0;        end
                S_M2:    begin state_next = S_M3; addr_next = ADDR_LAST; end
                S_M3:    begin state_next = S_M4; addr_next = ADDR_LAST; end
                S_M4:    begin state_next = S_M5; addr_next = '0;        end
                default: run_end = 1'b1;
            endcase
        end
    end

    assign miscompare = chk_reg && (mem.mem_rdata != {DATA_WIDTH{chk_exp_reg}});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            addr_reg        <= '0;
            phase_reg       <= 1'b0;
            mem_en_reg      <= 1'b0;
            mem_we_reg      <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
            chk_reg         <= 1'b0;
            chk_exp_reg     <= 1'b0;
            chk_addr_reg    <= '0;
            drain_reg       <= 1'b0;
            bist_busy       <= 1'b0;
            bist_done       <= 1'b0;
            bist_pass       <= 1'b0;
            fail_valid      <= 1'b0;
            fail_addr       <= '0;
            fail_count      <= '0;
            first_fail_addr <= '0;
        end else begin
            fail_valid   <= 1'b0;
            chk_reg      <= mem_en_reg & ~mem_we_reg;
            chk_exp_reg  <= read_bit(state_reg);
            chk_addr_reg <= mem_addr_reg;

            if (miscompare) begin
                fail_valid <= 1'b1;
                fail_addr  <= chk_addr_reg;
                if (fail_count != '1) begin
                    fail_count <= fail_count + CNT_WIDTH'(1);
                end
                if (fail_count == '0) begin
                    first_fail_addr <= chk_addr_reg;
                end
            end

            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        // First op (M0 w0 @ 0) goes out on the accept edge.
                        state_reg       <= S_M0;
                        addr_reg        <= '0;
                        phase_reg       <= 1'b0;
                        mem_en_reg      <= 1'b1;
                        mem_we_reg      <= 1'b1;
                        mem_addr_reg    <= '0;
                        mem_wdata_reg   <= '0;
                        bist_busy       <= 1'b1;
                        bist_done       <= 1'b0;
                        bist_pass       <= 1'b0;
                        fail_count      <= '0;
                        first_fail_addr <= '0;
                    end
                end
                S_DRAIN: begin
                    // Two cycles: the final M5 read is checked in the first,
                    // so pass below already reflects it.
                    drain_reg <= 1'b1;
                    if (drain_reg) begin
                        state_reg <= S_DONE;
                        bist_busy <= 1'b0;
                        bist_done <= 1'b1;
                        bist_pass <= (fail_count == '0);
                    end
                end
                default: begin
                    if (run_end) begin
                        state_reg  <= S_DRAIN;
                        mem_en_reg <= 1'b0;
                        mem_we_reg <= 1'b0;
                        drain_reg  <= 1'b0;
                    end else begin
                        state_reg    <= state_next;
                        addr_reg     <= addr_next;
                        phase_reg    <= phase_next;
                        mem_en_reg   <= 1'b1;
                        mem_we_reg   <= op_is_write(state_next, phase_next);
                        mem_addr_reg <= addr_next;
                        // Reads keep the last written background on wdata.
                        if (op_is_write(state_next, phase_next)) begin
                            mem_wdata_reg <= {DATA_WIDTH{write_bit(state_next)}};
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mbist_march_ctrl
// Self-checking bench for mbist_march_ctrl: a faultable memory model, a
// scoreboard of expected bus ops and expected miscompare events, and
// end-of-run status checks.
// ----------------------------------------------------------------------------
module tb_mbist_march_ctrl;
    localparam int AW   = 5;
    localparam int DW   = 8;
    localparam int MS   = 32;
    localparam int CW   = 8;
    localparam int NOPS = 10 * MS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    always #5 clk = ~clk;

    mbist_march_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    logic          bist_busy, bist_done, bist_pass, fail_valid;
    logic [AW-1:0] fail_addr, first_fail_addr;
    logic [CW-1:0] fail_count;

    mbist_march_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MS), .CNT_WIDTH(CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .mem             (mem_if),
        .bist_busy       (bist_busy),
        .bist_done       (bist_done),
        .bist_pass       (bist_pass),
        .fail_valid      (fail_valid),
        .fail_addr       (fail_addr),
        .fail_count      (fail_count),
        .first_fail_addr (first_fail_addr)
    );

    // Memory model with per-address stuck-at-1 / stuck-at-0 masks on read.
    logic [DW-1:0] mem_arr  [MS];
    logic [DW-1:0] sa1_mask [MS];
    logic [DW-1:0] sa0_mask [MS];
    logic [DW-1:0] rdata_reg = '0;
    assign mem_if.mem_rdata = rdata_reg;

    always @(posedge clk) begin
        if (mem_if.mem_en) begin
            if (mem_if.mem_we) mem_arr[mem_if.mem_addr] <= mem_if.mem_wdata;
            else rdata_reg <= (mem_arr[mem_if.mem_addr] | sa1_mask[mem_if.mem_addr])
                              & ~sa0_mask[mem_if.mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            rel;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] bg;
    } op_t;

    typedef struct {
        int            due;
        logic [AW-1:0] addr;
    } fail_t;

    op_t   op_q[$];
    fail_t fail_q[$];
    int    t0 = 0;
    bit    mon_on = 1'b0;
    int    tests_run = 0;
    int    tests_failed = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // March C- op list: M0 up w0; M1 up r0,w1; M2 up r1,w0;
    // M3 down r0,w1; M4 down r1,w0; M5 up r0.
    task automatic build_ops();
        bit [5:0]      e_down  = 6'b011000;
        bit [5:0]      e_has_r = 6'b111110;
        bit [5:0]      e_rv    = 6'b010100;
        bit [5:0]      e_has_w = 6'b011111;
        bit [5:0]      e_wv    = 6'b001010;
        int            n = 0;
        logic [DW-1:0] last = '0;
        op_t           op;
        op_q.delete();
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < MS; k++) begin
                int a = e_down[e] ? (MS - 1 - k) : k;
                if (e_has_r[e]) begin
                    op.rel = n; op.we = 1'b0; op.addr = AW'(a);
                    op.wdata = last; op.bg = {DW{e_rv[e]}};
                    op_q.push_back(op);
                    n++;
                end
                if (e_has_w[e]) begin
                    last = {DW{e_wv[e]}};
                    op.rel = n; op.we = 1'b1; op.addr = AW'(a);
                    op.wdata = last; op.bg = '0;
                    op_q.push_back(op);
                    n++;
                end
            end
        end
    endtask

    // Bus and fail-stream monitor.
    always @(negedge clk) begin
        if (mon_on) begin
            while (fail_q.size() > 0 && fail_q[0].due < cyc) begin
                check_val("fail_late", 64'(cyc), 64'(fail_q[0].due));
                void'(fail_q.pop_front());
            end
            if (mem_if.mem_en) begin
                if (op_q.size() == 0) begin
                    check_val("op_extra", 64'(op_q.size()), 64'd1);
                end else begin
                    op_t   e;
                    fail_t f;
                    e = op_q.pop_front();
                    check_val("op", {32'(cyc - t0), mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata},
                                    {32'(e.rel), e.we, e.addr, e.wdata});
                    if (!e.we && (((e.bg | sa1_mask[e.addr]) & ~sa0_mask[e.addr]) != e.bg)) begin
                        f.due = cyc + 2; f.addr = e.addr;
                        fail_q.push_back(f);
                    end
                end
            end
            if (fail_valid) begin
                if (fail_q.size() == 0) begin
                    check_val("fail_extra", 64'(fail_q.size()), 64'd1);
                end else begin
                    fail_t f;
                    f = fail_q.pop_front();
                    check_val("fail_evt", {32'(cyc), fail_addr}, {32'(f.due), f.addr});
                end
            end
        end
    end

    task automatic clear_faults();
        for (int i = 0; i < MS; i++) begin
            sa1_mask[i] = '0;
            sa0_mask[i] = '0;
        end
    endtask

    task automatic run_test(input string name, input bit hold, input int exp_count, input int exp_first);
        bit seen = 1'b0;
        int rel;
        build_ops();
        fail_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        mon_on = 1'b1;
        check_val({name, "_accept"}, {bist_busy, bist_done, bist_pass}, 3'b100);
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            start = hold && (k < 100 || k == 200);
            if (bist_done) begin
                seen = 1'b1;
                break;
            end
        end
        mon_on = 1'b0;
        start = 1'b0;
        rel = cyc - t0;
        check_val({name, "_done_seen"}, 64'(seen), 64'd1);
        check_val({name, "_done_edge"}, 64'(rel), 64'(NOPS + 2));
        check_val({name, "_pass"}, 64'(bist_pass), 64'(exp_count == 0));
        check_val({name, "_busy"}, 64'(bist_busy), 64'd0);
        check_val({name, "_count"}, 64'(fail_count), 64'(exp_count));
        check_val({name, "_first"}, 64'(first_fail_addr), 64'(exp_first));
        check_val({name, "_ops_left"}, 64'(op_q.size()), 64'd0);
        check_val({name, "_fails_left"}, 64'(fail_q.size()), 64'd0);
        $display("[TB] run %s: done at edge %0d pass=%0d count=%0d first=%0d",
                 name, rel, bist_pass, fail_count, first_fail_addr);
    endtask

    initial begin
        clear_faults();
        for (int i = 0; i < MS; i++) mem_arr[i] = '0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_status", {bist_busy, bist_done, bist_pass, fail_valid}, 4'b0000);
        check_val("rst_counts", {fail_count, first_fail_addr, fail_addr}, 64'd0);
        check_val("rst_bus", {mem_if.mem_en, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("idle_status", {bist_busy, bist_done, mem_if.mem_en}, 3'b000);

        run_test("clean", 1'b0, 0, 0);

        sa1_mask[5] = 8'h08;
        run_test("sa1_b3_a5", 1'b0, 3, 5);
        clear_faults();

        for (int i = 0; i < MS; i++) sa0_mask[i] = 8'h80;
        run_test("sa0_b7_all", 1'b0, 2 * MS, 0);
        clear_faults();

        run_test("start_held", 1'b1, 0, 0);

        // Reset in the middle of M2 (ops 97..160 -> edges 96..159).
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc - t0 < 110) @(negedge clk);
        check_val("pre_rst_en", 64'(mem_if.mem_en), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("midrst_bus", {mem_if.mem_en, mem_if.mem_we}, 2'b00);
        check_val("midrst_status", {bist_busy, bist_done, bist_pass, fail_valid}, 4'b0000);
        check_val("midrst_counts", {fail_count, first_fail_addr}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        $display("[TB] run mid_reset: reset applied at edge %0d", cyc - t0);

        run_test("after_reset", 1'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
